// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling
module uart_rx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic       rx_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [7:0] data_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_e;

  logic             rx_meta_q;
  logic             rx_sync_q;
  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic             ready_q,   ready_d;
  logic [7:0]       data_q,    data_d;

  // Synchronizer flops reset high so a reset never looks like a start bit edge.
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      ready_q   <= 1'b0;
      data_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ready_q   <= ready_d;
      data_q    <= data_d;
    end
  end

  // The counter only advances between samples and is cleared at every sample or
  // state change, so it never exceeds CLKS_PER_BIT-1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    ready_d   = 1'b0;
    data_d    = data_q;

    case (state_q)
      IDLE: begin
        bit_idx_d = 3'd0;
        if (valid_i && !rx_sync_q) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          state_d = rx_sync_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          if (rx_sync_q) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      WAIT_IDLE: begin
        if (rx_sync_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready_o = ready_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and randomized frame checks of uart_rx against a byte-level model
module tb_uart_rx;

  localparam int CLK_HZ  = 16_000_000;
  localparam int BAUD    = 1_000_000;
  localparam int CPB     = CLK_HZ / BAUD;
  localparam int NOMINAL = (19 * CPB) / 2;
  localparam int TOL     = 4;

  logic       clk = 1'b0;
  logic       nreset;
  logic       rx;
  logic       valid;
  logic       ready;
  logic [7:0] data;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD)
  ) dut (
    .clk_i   (clk),
    .nreset_i(nreset),
    .rx_i    (rx),
    .valid_i (valid),
    .ready_o (ready),
    .data_o  (data)
  );

  int   cyc = 0;
  int   pulses = 0;
  int   last_pulse = 0;
  int   double_hi = 0;
  logic prev_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ready === 1'b1) begin
      pulses     <= pulses + 1;
      last_pulse <= cyc;
      if (prev_ready === 1'b1) double_hi <= double_hi + 1;
    end
    prev_ready <= ready;
  end

  int         n_checks = 0;
  int         n_fail = 0;
  int         t0;
  logic [7:0] exp_data;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_bits(input int n);
    wait_cycles(n * CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic drop_valid);
    rx = 1'b0;
    t0 = cyc;
    wait_bits(1);
    if (drop_valid) valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_bits(1);
    end
    rx = stop_bit;
    wait_bits(1);
    rx = 1'b1;
  endtask

  // A frame produces a byte only if valid_i was high at its start and its stop bit is 1.
  task automatic run_frame(input string tag, input logic [7:0] b, input logic stop_bit,
                           input logic drop_valid);
    int   p0;
    logic accepted;
    p0       = pulses;
    accepted = valid && stop_bit;
    send_frame(b, stop_bit, drop_valid);
    if (accepted) exp_data = b;
    check({tag, "_pulses"}, pulses - p0, accepted ? 1 : 0);
    check({tag, "_data"}, int'(data), int'(exp_data));
    if (accepted) check_range({tag, "_latency"}, last_pulse - t0, NOMINAL - TOL, NOMINAL + TOL);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rv;
    logic       rs;
    int         p0;

    nreset   = 1'b0;
    rx       = 1'b1;
    valid    = 1'b0;
    exp_data = 8'h00;
    wait_cycles(20);
    check("reset_ready", int'(ready), 0);
    check("reset_data", int'(data), 0);
    nreset = 1'b1;
    valid  = 1'b1;
    wait_bits(50);
    check("idle_pulses", pulses, 0);
    check("idle_data", int'(data), 0);

    run_frame("f81", 8'h81, 1'b1, 1'b0);
    run_frame("f80_b2b", 8'h80, 1'b1, 1'b0);
    run_frame("f00_drop", 8'h00, 1'b1, 1'b1);
    wait_bits(1);
    run_frame("f55_novalid", 8'h55, 1'b1, 1'b0);

    valid = 1'b1;
    wait_bits(1);
    p0 = pulses;
    rx = 1'b0;
    wait_cycles(5);
    rx = 1'b1;
    wait_bits(2);
    check("glitch_pulses", pulses - p0, 0);
    check("glitch_data", int'(data), int'(exp_data));
    run_frame("f5a", 8'h5A, 1'b1, 1'b0);

    run_frame("f3c_ferr", 8'h3C, 1'b0, 1'b0);
    wait_bits(1);
    run_frame("fa5", 8'hA5, 1'b1, 1'b0);

    for (int k = 0; k < 8; k++) begin
      rb    = 8'($urandom);
      rv    = ($urandom_range(0, 3) != 0);
      rs    = ($urandom_range(0, 3) != 0);
      valid = rv;
      run_frame($sformatf("rnd%0d", k), rb, rs, 1'b0);
      wait_bits(rs ? $urandom_range(0, 2) : $urandom_range(1, 2));
    end

    valid = 1'b1;
    wait_bits(1);
    p0 = pulses;
    rx = 1'b0;
    wait_bits(4);
    nreset = 1'b0;
    wait_bits(2);
    rx = 1'b1;
    wait_bits(8);
    nreset   = 1'b1;
    exp_data = 8'h00;
    wait_bits(4);
    check("midrst_pulses", pulses - p0, 0);
    check("midrst_data", int'(data), 0);
    run_frame("after_rst", 8'($urandom), 1'b1, 1'b0);

    check("no_double_strobe", double_hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
